i2c_master: RTL

- Byte-oriented I2C master that sits directly downstream of the sensor control FSM.
- Accepts a 7-bit address, a rw flag and an enable, and generates START, address, data, ACK and STOP on open-drain scl/sda.
- Reports progress through busy; ena, busy, addr and rw form the handshake used by every sensor controller in the SoC, for example the UV sensor at address 0x38.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_clk_div.sv | 37 +++
 rtl/i2c_master.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - state encoding, quarter-phase indices and divider helper for i2c_master
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_SACK_ADDR,
    ST_WR,
    ST_SACK_WR,
    ST_RD,
    ST_MACK,
    ST_STOP
  } state_e;

  // Quarter-bit phases: scl low in Q0/Q1, released in Q2/Q3
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Clocks per quarter of an SCL period
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// rtl/i2c_clk_div.sv - quarter-period tick generator; freeze input present with I2C_CLK_STRETCH_EN
module i2c_clk_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
`ifdef I2C_CLK_STRETCH_EN
  input  logic freeze_i,
`endif
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          hold;

`ifdef I2C_CLK_STRETCH_EN
  assign hold = freeze_i;
`else
  assign hold = 1'b0;
`endif

  // Free-running count held at zero while restarting, paused while frozen
  always_ff @(posedge clk) begin
    if (rst || restart_i) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_o = !rst && !restart_i && !hold && (cnt_q == LAST);

endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - byte-oriented open-drain I2C master; optional slave clock stretching via I2C_CLK_STRETCH_EN
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned I2C_FREQ = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic       ena,
  input  logic [7:0] data_wr,
  output logic       busy,
  output logic [7:0] data_rd,
  output logic       rd_valid,
  output logic       ack_error,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, I2C_FREQ);

  state_e     state_q;
  logic [1:0] phase_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic [6:0] addr_q;
  logic       rw_q;
  logic [7:0] data_q;
  logic       cont_q;
  logic       busy_q;
  logic [7:0] data_rd_q;
  logic       rd_valid_q;
  logic       ack_error_q;
  logic       scl_low_q;
  logic       sda_low_q;

  logic       tick;
  logic       sda_in;
  logic       match;
  logic [1:0] nq;

  assign sda_in = sda;
  assign nq     = phase_q + 2'd1;
  // Continue only while the controller still asks for the same slave and direction
  assign match  = ena && (addr == addr_q) && (rw == rw_q);

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync_q;
  logic       freeze;

  // Two-flop synchronizer on the returned scl level
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
    end
  end

  // Released scl still reads low during Q2: the slave is stretching
  assign freeze = (state_q != ST_IDLE) && (phase_q == Q2) && !scl_low_q && !scl_sync_q[1];

  i2c_clk_div #(.DIV(DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .restart_i (state_q == ST_IDLE),
    .freeze_i  (freeze),
    .tick_o    (tick)
  );
`else
  i2c_clk_div #(.DIV(DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .restart_i (state_q == ST_IDLE),
    .tick_o    (tick)
  );
`endif

  // Transaction sequencer: IDLE handshake, then one quarter-bit step per divider tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= Q3;
      bit_q       <= 3'd7;
      sh_q        <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      data_q      <= '0;
      cont_q      <= 1'b0;
      busy_q      <= 1'b0;
      data_rd_q   <= '0;
      rd_valid_q  <= 1'b0;
      ack_error_q <= 1'b0;
      scl_low_q   <= 1'b0;
      sda_low_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        scl_low_q <= 1'b0;
        sda_low_q <= 1'b0;
        phase_q   <= Q3;
        bit_q     <= 3'd7;
        if (ena) begin
          addr_q      <= addr;
          rw_q        <= rw;
          data_q      <= data_wr;
          sh_q        <= {addr, rw};
          ack_error_q <= 1'b0;
          busy_q      <= 1'b1;
          state_q     <= ST_START;
        end
      end else if (tick) begin
        phase_q <= nq;
        case (nq)
          Q0: begin
            if (state_q != ST_START) scl_low_q <= 1'b1;
            case (state_q)
              ST_ADDR, ST_WR:                  sda_low_q <= ~sh_q[7];
              ST_SACK_ADDR, ST_SACK_WR, ST_RD: sda_low_q <= 1'b0;
              ST_MACK: begin
                sda_low_q <= match;
                cont_q    <= match;
              end
              ST_STOP:                         sda_low_q <= 1'b1;
              default:                         ;
            endcase
          end
          Q1: if (state_q == ST_START) sda_low_q <= 1'b1;
          Q2: if (state_q != ST_START) scl_low_q <= 1'b0;
          default: begin
            // Q3 entry: sample the bus and choose what the next bit is
            case (state_q)
              ST_START: begin
                scl_low_q <= 1'b1;
                state_q   <= ST_ADDR;
              end
              ST_ADDR, ST_WR: begin
                sh_q  <= {sh_q[6:0], 1'b0};
                bit_q <= bit_q - 3'd1;
                if (bit_q == 3'd0) state_q <= (state_q == ST_ADDR) ? ST_SACK_ADDR : ST_SACK_WR;
              end
              ST_SACK_ADDR: begin
                if (sda_in) begin
                  ack_error_q <= 1'b1;
                  state_q     <= ST_STOP;
                end else if (rw_q) begin
                  state_q <= ST_RD;
                end else begin
                  sh_q    <= data_q;
                  state_q <= ST_WR;
                end
              end
              ST_SACK_WR: begin
                if (sda_in) begin
                  ack_error_q <= 1'b1;
                  state_q     <= ST_STOP;
                end else if (match) begin
                  sh_q    <= data_wr;
                  state_q <= ST_WR;
                end else begin
                  state_q <= ST_STOP;
                end
              end
              ST_RD: begin
                sh_q  <= {sh_q[6:0], sda_in};
                bit_q <= bit_q - 3'd1;
                if (bit_q == 3'd0) begin
                  data_rd_q  <= {sh_q[6:0], sda_in};
                  rd_valid_q <= 1'b1;
                  state_q    <= ST_MACK;
                end
              end
              ST_MACK: state_q <= cont_q ? ST_RD : ST_STOP;
              ST_STOP: begin
                sda_low_q <= 1'b0;
                busy_q    <= 1'b0;
                state_q   <= ST_IDLE;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        endcase
      end
    end
  end

  assign scl       = scl_low_q ? 1'b0 : 1'bz;
  assign sda       = sda_low_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign data_rd   = data_rd_q;
  assign rd_valid  = rd_valid_q;
  assign ack_error = ack_error_q;

endmodule
